// File: rtl/stream_demux_n.sv
// 1-to-N_CH stream demultiplexer with one registered output slot per channel,
// fixed (sel) or round-robin scan routing. Optional per-channel beat counters under DEMUX_COUNT_EN.
module stream_demux_n #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  sel_err
`ifdef DEMUX_COUNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] beat_cnt
`endif
);

    localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    // Handshake: a beat moves on any edge where valid && ready on that interface.
    // in_ready never looks at in_valid; a slot's data is frozen while valid && !ready.
    logic [SEL_W-1:0]      scan_ptr_q, scan_ptr_d;
    logic [N_CH-1:0]       out_valid_q, out_valid_d;
    logic [N_CH*WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]      tgt;
    logic                  tgt_free;
    logic                  sel_err_c;
    logic                  in_ready_c;
    logic                  accept;
    logic [N_CH-1:0]       load;

    always_comb begin
        tgt       = mode ? scan_ptr_q : sel;
        sel_err_c = !mode && ({1'b0, sel} >= N_CH_X);
        tgt_free  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_free = !out_valid_q[k] || out_ready[k];
            end
        end
        in_ready_c = en && !sel_err_c && tgt_free;
        accept     = in_valid && in_ready_c;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = accept && (tgt == SEL_W'(k));
        end
    end

    // A load wins over a drain on the same slot, giving one beat per cycle per channel.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < N_CH; k++) begin
            if (load[k]) begin
                out_valid_d[k]                = 1'b1;
                out_data_d[k*WIDTH +: WIDTH]  = in_data;
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        if (!mode) begin
            scan_ptr_d = '0;
        end else if (accept) begin
            scan_ptr_d = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + SEL_W'(1);
        end else begin
            scan_ptr_d = scan_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr_q  <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            scan_ptr_q  <= scan_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            if (load[k]) begin
                cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;
`else
    // Counter-free build: nothing beyond the routing datapath.
`endif

    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = tgt;
    assign sel_err   = sel_err_c;

endmodule
